// File: rtl/aoi_selftest_ctrl.sv
// Self-test sequencer for two AND-OR-INVERT implementations.
// Sweeps all 16 vectors on abcd. Checks tz1/tz2 against each other and the golden model.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start, abort      run request / cancel a run in progress
//   abcd              vector driven to both AOI instances (A,B,C,D = bits 3..0)
//   tz1, tz2          outputs of the two implementations
//   exp_tz            golden ~((A&B)|(C&D)) for the current abcd
//   busy, done, pass  run status
//   err_count         number of failing vectors
//   first_err_vec     abcd of the first failing vector
//   first_err_valid   first_err_vec holds a captured vector
module aoi_selftest_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic [3:0] abcd,
    input  logic       tz1,
    input  logic       tz2,
    output logic       exp_tz,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_err_vec,
    output logic       first_err_valid
);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        COMPARE,
        DONE
    } state_t;

    // Last counter value spent in SETTLE; unused when SETTLE_CYCLES is 0.
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);

    state_t           state_q, state_d;
    logic [3:0]       abcd_q, abcd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [4:0]       err_q, err_d;
    logic [3:0]       fev_q, fev_d;
    logic             fevv_q, fevv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic mismatch;

    assign exp_tz   = ~((abcd_q[3] & abcd_q[2]) | (abcd_q[1] & abcd_q[0]));
    assign mismatch = (tz1 != tz2) || (tz1 != exp_tz);

    always_comb begin
        state_d = state_q;
        abcd_d  = abcd_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        fev_d   = fev_q;
        fevv_d  = fevv_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE, DONE: begin
                // abort is meaningless here; only start matters.
                if (start) begin
                    state_d = APPLY;
                    abcd_d  = 4'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 5'd0;
                    fev_d   = 4'd0;
                    fevv_d  = 1'b0;
                end
            end
            APPLY: begin
                cnt_d = '0;
                if (SETTLE_CYCLES > 0) begin
                    state_d = SETTLE;
                end else begin
                    state_d = COMPARE;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (mismatch) begin
                    err_d = err_q + 5'd1;
                    if (!fevv_q) begin
                        fev_d  = abcd_q;
                        fevv_d = 1'b1;
                    end
                end
                if (abcd_q == 4'd15) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    abcd_d  = abcd_q + 4'd1;
                    state_d = APPLY;
                end
            end
            default: begin
                state_d = IDLE;
                abcd_d  = 4'd0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase

        // Abort overrides everything a busy state decided above,
        // including the COMPARE result update, but keeps old results.
        if (abort && busy_q) begin
            state_d = IDLE;
            abcd_d  = 4'd0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            err_d   = err_q;
            fev_d   = fev_q;
            fevv_d  = fevv_q;
            cnt_d   = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            abcd_q  <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 5'd0;
            fev_q   <= 4'd0;
            fevv_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            abcd_q  <= abcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fevv_q  <= fevv_d;
            cnt_q   <= cnt_d;
        end
    end

    assign abcd            = abcd_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err_count       = err_q;
    assign first_err_vec   = fev_q;
    assign first_err_valid = fevv_q;
    assign pass            = done_q && (err_q == 5'd0);

endmodule

// File: tb/tb_aoi_selftest_ctrl.sv
// Directed bench for aoi_selftest_ctrl.
// Runs instance dut with the default settle time and instance dut0 with SETTLE_CYCLES=0.
module tb_aoi_selftest_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [3:0] abcd;
    logic       tz1;
    logic       tz2;
    logic       exp_tz;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic [3:0] first_err_vec;
    logic       first_err_valid;

    logic       start0;
    logic       abort0;
    logic [3:0] abcd0;
    logic       tz0;
    logic       exp_tz0;
    logic       busy0;
    logic       done0;
    logic       pass0;
    logic [4:0] err_count0;
    logic [3:0] first_err_vec0;
    logic       first_err_valid0;

    int checks;
    int failures;
    int mode;
    logic g;

    aoi_selftest_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .abcd(abcd), .tz1(tz1), .tz2(tz2), .exp_tz(exp_tz),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_vec(first_err_vec), .first_err_valid(first_err_valid)
    );

    aoi_selftest_ctrl #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .abcd(abcd0), .tz1(tz0), .tz2(tz0), .exp_tz(exp_tz0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err_count0),
        .first_err_vec(first_err_vec0), .first_err_valid(first_err_valid0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference AOI and the modelled implementations under test.
    assign g   = ~((abcd[3] & abcd[2]) | (abcd[1] & abcd[0]));
    assign tz0 = ~((abcd0[3] & abcd0[2]) | (abcd0[1] & abcd0[0]));

    always_comb begin
        tz1 = g;
        tz2 = g;
        if (mode == 1) begin
            tz2 = 1'b0;
        end else if (mode == 2) begin
            tz1 = ~g;
            tz2 = ~g;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || abcd !== 4'd0) begin
            failures++;
            $display("FAIL reset_ctl busy=%b done=%b abcd=%0d want 0 0 0",
                     busy, done, abcd);
        end
        checks++;
        if (err_count !== 5'd0 || first_err_valid !== 1'b0 ||
            first_err_vec !== 4'd0 || pass !== 1'b0) begin
            failures++;
            $display("FAIL reset_res err=%0d fv=%b fev=%0d pass=%b want 0 0 0 0",
                     err_count, first_err_valid, first_err_vec, pass);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || abcd !== 4'd0) begin
            failures++;
            $display("FAIL idle_after_reset busy=%b abcd=%0d want 0 0",
                     busy, abcd);
        end
    endtask

    task automatic test_pass_run();
        int cyc;
        int bad_seq;
        mode = 0;
        pulse_start();
        cyc = 0;
        bad_seq = 0;
        while (done !== 1'b1 && cyc < 200) begin
            if (abcd !== 4'(cyc / 4) || busy !== 1'b1 || exp_tz !== g) begin
                bad_seq++;
                if (bad_seq == 1) begin
                    $display("FAIL seq cyc=%0d abcd=%0d busy=%b exp=%b want %0d 1 %b",
                             cyc, abcd, busy, exp_tz, cyc / 4, g);
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (bad_seq != 0) failures++;
        checks++;
        if (cyc != 64) begin
            failures++;
            $display("FAIL run_len got=%0d want 64", cyc);
        end
        checks++;
        if (pass !== 1'b1 || err_count !== 5'd0 || first_err_valid !== 1'b0) begin
            failures++;
            $display("FAIL good_res pass=%b err=%0d fv=%b want 1 0 0",
                     pass, err_count, first_err_valid);
        end
        checks++;
        if (abcd !== 4'd15 || busy !== 1'b0) begin
            failures++;
            $display("FAIL done_hold abcd=%0d busy=%b want 15 0", abcd, busy);
        end
    endtask

    task automatic test_stuck_tz2();
        int cyc;
        mode = 1;
        pulse_start();
        wait_done(cyc);
        checks++;
        if (cyc != 64) begin
            failures++;
            $display("FAIL stuck_len got=%0d want 64", cyc);
        end
        checks++;
        if (err_count !== 5'd9 || first_err_vec !== 4'd0 ||
            first_err_valid !== 1'b1 || pass !== 1'b0) begin
            failures++;
            $display("FAIL stuck_res err=%0d fev=%0d fv=%b pass=%b want 9 0 1 0",
                     err_count, first_err_vec, first_err_valid, pass);
        end
    endtask

    task automatic test_golden_catch();
        int cyc;
        mode = 2;
        pulse_start();
        wait_done(cyc);
        checks++;
        if (cyc != 64 || err_count !== 5'd16 || first_err_vec !== 4'd0 ||
            pass !== 1'b0) begin
            failures++;
            $display("FAIL golden len=%0d err=%0d fev=%0d pass=%b want 64 16 0 0",
                     cyc, err_count, first_err_vec, pass);
        end
    endtask

    task automatic test_settle0();
        int cyc;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        cyc = 0;
        while (done0 !== 1'b1 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (cyc != 32 || pass0 !== 1'b1 || err_count0 !== 5'd0) begin
            failures++;
            $display("FAIL settle0 len=%0d pass=%b err=%0d want 32 1 0",
                     cyc, pass0, err_count0);
        end
    endtask

    task automatic test_abort();
        int cyc;
        mode = 1;
        pulse_start();
        repeat (21) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (abcd !== 4'd5 || busy !== 1'b1) begin
            failures++;
            $display("FAIL pre_abort abcd=%0d busy=%b want 5 1", abcd, busy);
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || abcd !== 4'd0) begin
            failures++;
            $display("FAIL abort_ctl busy=%b done=%b abcd=%0d want 0 0 0",
                     busy, done, abcd);
        end
        checks++;
        if (err_count !== 5'd4 || first_err_valid !== 1'b1 ||
            first_err_vec !== 4'd0) begin
            failures++;
            $display("FAIL abort_keep err=%0d fv=%b fev=%0d want 4 1 0",
                     err_count, first_err_valid, first_err_vec);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || abcd !== 4'd0 || err_count !== 5'd4) begin
            failures++;
            $display("FAIL abort_idle busy=%b abcd=%0d err=%0d want 0 0 4",
                     busy, abcd, err_count);
        end
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b1 || err_count !== 5'd0 || first_err_valid !== 1'b0) begin
            failures++;
            $display("FAIL start_wins busy=%b err=%0d fv=%b want 1 0 0",
                     busy, err_count, first_err_valid);
        end
        repeat (28) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (abcd !== 4'd7) begin
            failures++;
            $display("FAIL mid_run abcd=%0d want 7", abcd);
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc);
        checks++;
        if (cyc + 29 != 64 || pass !== 1'b1 || err_count !== 5'd0) begin
            failures++;
            $display("FAIL busy_start len=%0d pass=%b err=%0d want 64 1 0",
                     cyc + 29, pass, err_count);
        end
    endtask

    task automatic test_async_reset();
        mode = 1;
        pulse_start();
        repeat (37) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (abcd !== 4'd9 || err_count !== 5'd7) begin
            failures++;
            $display("FAIL pre_reset abcd=%0d err=%0d want 9 7", abcd, err_count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (abcd !== 4'd0 || busy !== 1'b0 || done !== 1'b0 ||
            err_count !== 5'd0 || first_err_vec !== 4'd0 ||
            first_err_valid !== 1'b0 || pass !== 1'b0) begin
            failures++;
            $display("FAIL async_rst abcd=%0d busy=%b done=%b err=%0d fev=%0d fv=%b",
                     abcd, busy, done, err_count, first_err_vec, first_err_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (abcd !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL post_rst abcd=%0d busy=%b done=%b want 0 0 0",
                     abcd, busy, done);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        mode     = 0;
        start    = 1'b0;
        abort    = 1'b0;
        start0   = 1'b0;
        abort0   = 1'b0;
        rst_n    = 1'b0;
        test_reset();
        test_pass_run();
        test_stuck_tz2();
        test_golden_catch();
        test_settle0();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
